// File: rtl/regfile_pkg.sv
// Shared RV32I register-file constants, also used by the pipeline-stage latches.
package regfile_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile.sv
// RV32I integer register file: WB commit, two registered source reads with WB bypass,
// STALL/FLUSH read-latch control and a retired-write counter.
module regfile #(
  parameter int unsigned XLEN    = regfile_pkg::XLEN,
  parameter int unsigned REG_NUM = 32
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  STALL,
  input  logic                                  FLUSH,
  input  logic                                  W_VALID,
  input  logic [regfile_pkg::REG_ADDR_W-1:0]    W_REG_D,
  input  logic [XLEN-1:0]                       W_REG_D_V,
  input  logic [regfile_pkg::REG_ADDR_W-1:0]    D_REG_S1,
  input  logic [regfile_pkg::REG_ADDR_W-1:0]    D_REG_S2,
  output logic [regfile_pkg::REG_ADDR_W-1:0]    R_REG_S1,
  output logic [XLEN-1:0]                       R_REG_S1_V,
  output logic [regfile_pkg::REG_ADDR_W-1:0]    R_REG_S2,
  output logic [XLEN-1:0]                       R_REG_S2_V,
  output logic [XLEN-1:0]                       R_WR_CNT
);
  import regfile_pkg::*;

  logic [XLEN-1:0]       rf [1:REG_NUM-1];
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] rd_a1, rd_a2;
  logic [XLEN-1:0]       rd_v1, rd_v2;

  // x0 reads as zero; a same-cycle WB write to the looked-up register is forwarded.
  function automatic logic [XLEN-1:0] rd(input logic [REG_ADDR_W-1:0] a);
    if (a == REG_ZERO)
      return '0;
    else if (W_VALID && W_REG_D == a)
      return W_REG_D_V;
    else
      return rf[a];
  endfunction

  assign wr_en = W_VALID && (W_REG_D != REG_ZERO);

  always_comb begin
    rd_a1 = STALL ? R_REG_S1 : D_REG_S1;
    rd_a2 = STALL ? R_REG_S2 : D_REG_S2;
    rd_v1 = rd(rd_a1);
    rd_v2 = rd(rd_a2);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 1; i < REG_NUM; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[W_REG_D] <= W_REG_D_V;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      R_REG_S1   <= '0;
      R_REG_S2   <= '0;
      R_REG_S1_V <= '0;
      R_REG_S2_V <= '0;
    end else if (FLUSH) begin
      R_REG_S1   <= '0;
      R_REG_S2   <= '0;
      R_REG_S1_V <= '0;
      R_REG_S2_V <= '0;
    end else begin
      // rd_a* already selects the held index under STALL, so values keep refreshing.
      R_REG_S1   <= rd_a1;
      R_REG_S2   <= rd_a2;
      R_REG_S1_V <= rd_v1;
      R_REG_S2_V <= rd_v2;
    end
  end

  // A stalled WB slot is counted once, on the edge that releases it (or flushes it).
  always_ff @(posedge CLK) begin
    if (RST)
      R_WR_CNT <= '0;
    else if ((!STALL || FLUSH) && wr_en)
      R_WR_CNT <= R_WR_CNT + 1'b1;
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table plus randomized cycles against a model.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst, stall, flush, w_valid;
  logic [4:0]  w_reg_d, d_reg_s1, d_reg_s2;
  logic [31:0] w_reg_d_v;
  logic [4:0]  r_reg_s1, r_reg_s2;
  logic [31:0] r_reg_s1_v, r_reg_s2_v, r_wr_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state
  logic [31:0] m_rf [32];
  logic [4:0]  m_s1, m_s2;
  logic [31:0] m_v1, m_v2, m_cnt;

  typedef struct {
    logic        rst, flush, stall, wv;
    logic [4:0]  wd;
    logic [31:0] wdv;
    logic [4:0]  s1, s2;
    logic [4:0]  e_s1, e_s2;
    logic [31:0] e_v1, e_v2, e_cnt;
  } vec_t;

  vec_t tbl [13];

  regfile #(.XLEN(32), .REG_NUM(32)) dut (
    .CLK(clk), .RST(rst), .STALL(stall), .FLUSH(flush),
    .W_VALID(w_valid), .W_REG_D(w_reg_d), .W_REG_D_V(w_reg_d_v),
    .D_REG_S1(d_reg_s1), .D_REG_S2(d_reg_s2),
    .R_REG_S1(r_reg_s1), .R_REG_S1_V(r_reg_s1_v),
    .R_REG_S2(r_reg_s2), .R_REG_S2_V(r_reg_s2_v),
    .R_WR_CNT(r_wr_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lookup(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (w_valid && w_reg_d == a) return w_reg_d_v;
    return m_rf[a];
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    logic [4:0] a1, a2;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_s1 = 0; m_s2 = 0; m_v1 = 0; m_v2 = 0; m_cnt = 0;
    end else begin
      a1 = stall ? m_s1 : d_reg_s1;
      a2 = stall ? m_s2 : d_reg_s2;
      if (flush) begin
        m_s1 = 0; m_s2 = 0; m_v1 = 0; m_v2 = 0;
      end else begin
        m_v1 = lookup(a1); m_v2 = lookup(a2);
        m_s1 = a1; m_s2 = a2;
      end
      if (w_valid && w_reg_d != 0) begin
        m_rf[w_reg_d] = w_reg_d_v;
        if (!stall || flush) m_cnt = m_cnt + 32'd1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input bit use_tbl, input int idx);
    @(negedge clk);
    rst = v.rst; flush = v.flush; stall = v.stall; w_valid = v.wv;
    w_reg_d = v.wd; w_reg_d_v = v.wdv; d_reg_s1 = v.s1; d_reg_s2 = v.s2;
    model_step();
    @(posedge clk);
    #1;
    vectors++;
    if (use_tbl) begin
      check($sformatf("tbl%0d s1", idx),  {27'd0, r_reg_s1}, {27'd0, v.e_s1});
      check($sformatf("tbl%0d s2", idx),  {27'd0, r_reg_s2}, {27'd0, v.e_s2});
      check($sformatf("tbl%0d v1", idx),  r_reg_s1_v, v.e_v1);
      check($sformatf("tbl%0d v2", idx),  r_reg_s2_v, v.e_v2);
      check($sformatf("tbl%0d cnt", idx), r_wr_cnt,   v.e_cnt);
    end else begin
      check($sformatf("rnd%0d s1", idx),  {27'd0, r_reg_s1}, {27'd0, m_s1});
      check($sformatf("rnd%0d s2", idx),  {27'd0, r_reg_s2}, {27'd0, m_s2});
      check($sformatf("rnd%0d v1", idx),  r_reg_s1_v, m_v1);
      check($sformatf("rnd%0d v2", idx),  r_reg_s2_v, m_v2);
      check($sformatf("rnd%0d cnt", idx), r_wr_cnt,   m_cnt);
    end
  endtask

  initial begin
    vec_t v;
    rst = 1; stall = 0; flush = 0; w_valid = 0;
    w_reg_d = 0; w_reg_d_v = 0; d_reg_s1 = 0; d_reg_s2 = 0;

    //          rst fl st wv wd  wdv           s1  s2  e_s1 e_s2 e_v1          e_v2          e_cnt
    tbl[0]  = '{1, 0, 0, 0, 0,  32'h0,        0,  0,  0,  0,  32'h0,        32'h0,        0};
    tbl[1]  = '{0, 0, 0, 0, 0,  32'h0,        5,  0,  5,  0,  32'h0,        32'h0,        0};
    tbl[2]  = '{0, 0, 0, 1, 3,  32'hDEADBEEF, 0,  0,  0,  0,  32'h0,        32'h0,        1};
    tbl[3]  = '{0, 0, 0, 1, 7,  32'h12345678, 3,  7,  3,  7,  32'hDEADBEEF, 32'h12345678, 2};
    tbl[4]  = '{0, 0, 0, 1, 0,  32'hFFFFFFFF, 0,  0,  0,  0,  32'h0,        32'h0,        2};
    tbl[5]  = '{0, 0, 0, 0, 0,  32'h0,        9,  3,  9,  3,  32'h0,        32'hDEADBEEF, 2};
    tbl[6]  = '{0, 0, 1, 1, 9,  32'hA5A5A5A5, 1,  1,  9,  3,  32'hA5A5A5A5, 32'hDEADBEEF, 2};
    tbl[7]  = '{0, 0, 1, 1, 9,  32'hA5A5A5A5, 2,  2,  9,  3,  32'hA5A5A5A5, 32'hDEADBEEF, 2};
    tbl[8]  = '{0, 0, 0, 1, 9,  32'hA5A5A5A5, 9,  9,  9,  9,  32'hA5A5A5A5, 32'hA5A5A5A5, 3};
    tbl[9]  = '{0, 1, 1, 1, 4,  32'hCAFEF00D, 4,  4,  0,  0,  32'h0,        32'h0,        4};
    tbl[10] = '{0, 0, 0, 0, 0,  32'h0,        4,  3,  4,  3,  32'hCAFEF00D, 32'hDEADBEEF, 4};
    tbl[11] = '{1, 0, 0, 1, 5,  32'h00000001, 4,  3,  0,  0,  32'h0,        32'h0,        0};
    tbl[12] = '{0, 0, 0, 0, 0,  32'h0,        4,  5,  4,  5,  32'h0,        32'h0,        0};

    for (int i = 0; i < 13; i++) apply(tbl[i], 1'b1, i);

    // Randomized phase, starting from a clean reset.
    v = tbl[0];
    apply(v, 1'b0, -1);
    for (int n = 0; n < 3000; n++) begin
      v.rst   = ($urandom_range(0, 99) == 0);
      v.flush = ($urandom_range(0, 7) == 0);
      v.stall = ($urandom_range(0, 3) == 0);
      v.wv    = $urandom_range(0, 1) == 1;
      v.wd    = 5'($urandom_range(0, 31));
      v.wdv   = $urandom;
      v.s1    = ($urandom_range(0, 3) == 0) ? v.wd : 5'($urandom_range(0, 31));
      v.s2    = ($urandom_range(0, 7) == 0) ? v.s1 : 5'($urandom_range(0, 31));
      apply(v, 1'b0, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
